fpu_result_queue: RTL and testbench
===================================

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1, single clock for all state.
REQ-003 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port push_valid, input, 1, FPU result valid, one cycle per result.
REQ-005 SHALL have port push_data, input, 32, FPU result word.
REQ-006 SHALL have port push_exc, input, 5, result exception flags {NV,DZ,OF,UF,NX}, bit 4 down to bit 0.
REQ-007 SHALL have port push_unit, input, 4, index of the producing unit, 0..10 in valid-vector bit order.
REQ-008 SHALL have port pop, input, 1, consume head entry.
REQ-009 SHALL have port clr_flags, input, 1, clear sticky flags.
REQ-010 SHALL have port head_data, output, 32, head result word.
REQ-011 SHALL have port head_exc, output, 5, head exception flags.
REQ-012 SHALL have port head_unit, output, 4, head producing unit.
REQ-013 SHALL have port empty, output, 1, queue empty.
REQ-014 SHALL have port full, output, 1, queue full.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries.
REQ-016 SHALL have port fflags, output, 5, sticky OR of the exception flags of all accepted results.
REQ-017 SHALL have port overflow, output, 1, sticky flag for a result dropped while the queue was full.
REQ-018 SHALL have port underflow, output, 1, sticky flag for a pop while the queue was empty.
REQ-019 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-020 SHALL implement a first-word-fall-through circular buffer with write pointer and read pointer, each $clog2(DEPTH) bits wide, each wrapping from DEPTH-1 to 0.
REQ-021 SHALL accept a push on a rising edge when push_valid=1 and (full=0 or pop=1 with empty=0); an accepted entry is visible at the head from the next cycle if the queue was empty.
REQ-022 SHALL drive head_data, head_exc and head_unit to 0 while empty=1, otherwise to the entry at the read pointer.
REQ-023 SHALL remove the head entry on an edge with pop=1 and empty=0.
REQ-024 SHALL treat pop=1 with empty=1 as a no-op on the buffer and set underflow; a simultaneous push is still accepted.
REQ-025 SHALL, on simultaneous push and pop while full, accept both operations and leave count unchanged.
REQ-026 SHALL, on push_valid=1 with full=1 and pop=0, discard the result, set overflow, and leave fflags unchanged.
REQ-027 SHALL drive count equal to accepted pushes minus effective pops; empty=(count==0); full=(count==DEPTH).
REQ-028 SHALL OR push_exc into fflags on each accepted push.
REQ-029 SHALL, when clr_flags=1, clear fflags, overflow and underflow on that edge; if an event occurs in the same cycle, the new event's value is what gets registered.
REQ-030 SHALL take no action on push_data, push_exc or push_unit when push_valid=0.

Reset
REQ-031 SHALL, on rst_l=0 (asynchronous), clear pointers, count, fflags, overflow, underflow and irq; outputs are then empty=1, full=0, head_*=0.
REQ-032 SHALL discard all stored entries and any in-flight push or pop on a reset asserted mid-operation.
REQ-033 SHALL not require storage array contents to be reset.

Configuration
REQ-034 SHALL, with FPU_RESULT_QUEUE_IRQ_EN defined, register irq as (empty=0) OR (fflags[4:3]!=0) OR overflow, updated one cycle after the cause.
REQ-035 SHALL, without FPU_RESULT_QUEUE_IRQ_EN, tie irq to constant 0 and include no irq flop.

Verification
REQ-036 SHALL cover this scenario: DEPTH=4; push 0x3F800000/exc 0/unit 6, then 0x40000000/exc 1/unit 7 -> head is 0x3F800000 with unit 6; after one pop, head is 0x40000000 with exc 1; count sequence 1,2,1.
REQ-037 SHALL cover this scenario: push 5 results without popping -> full=1 after the 4th push; the 5th sets overflow=1; fflags excludes the 5th result's exc; the head is the 1st result.
REQ-038 SHALL cover this scenario: while full, push and pop in the same cycle -> count stays 4, head advances, and the new entry is at the tail; continue through 8 operations to exercise pointer wrap.
REQ-039 SHALL cover this scenario: pop while empty together with a push of exc 5'b10000 -> underflow=1, count=1, fflags=5'b10000, and irq=1 a cycle later (IRQ_EN build).
REQ-040 SHALL cover this scenario: assert clr_flags in the same cycle as a push with exc 5'b00001 -> fflags=5'b00001 and overflow=underflow=0.
REQ-041 SHALL cover this scenario: assert rst_l=0 mid-clock with 3 entries stored -> empty=1, count=0 and fflags=0 immediately, before the next edge.

Source files
------------

// File: rtl/fpu_result_queue.sv
// First-word-fall-through result queue for FPU writeback with sticky exception flags.
// Optional registered interrupt output enabled by defining FPU_RESULT_QUEUE_IRQ_EN.
module fpu_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     push_valid,
  input  logic [31:0]              push_data,
  input  logic [4:0]               push_exc,
  input  logic [3:0]               push_unit,
  input  logic                     pop,
  input  logic                     clr_flags,
  output logic [31:0]              head_data,
  output logic [4:0]               head_exc,
  output logic [3:0]               head_unit,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [4:0]               fflags,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 41;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] mem [DEPTH];

  logic          do_push;
  logic          do_pop;
  logic          ovf_evt;
  logic          udf_evt;
  logic [4:0]    acc_exc;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees a slot on the same edge, so a push into a full queue still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push_valid && (!full || do_pop);
  assign ovf_evt = push_valid && !do_push;
  assign udf_evt = pop && empty;
  assign acc_exc = do_push ? push_exc : 5'b0;

  assign {head_unit, head_exc, head_data} = empty ? {EW{1'b0}} : mem[rd_ptr];

  // Storage array is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_unit, push_exc, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear loses to an event on the same edge: the new event is what remains.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fflags    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_flags) begin
      fflags    <= acc_exc;
      overflow  <= ovf_evt;
      underflow <= udf_evt;
    end else begin
      fflags    <= fflags | acc_exc;
      overflow  <= overflow | ovf_evt;
      underflow <= underflow | udf_evt;
    end
  end

`ifdef FPU_RESULT_QUEUE_IRQ_EN
  // Interrupt follows its causes by one cycle; NV and DZ are the only flags that raise it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      irq <= 1'b0;
    end else begin
      irq <= !empty || (fflags[4:3] != 2'b00) || overflow;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// Scoreboard bench for fpu_result_queue: driver queues expected entries, negedge monitor checks the head.
module tb_fpu_result_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_l;
  logic          push_valid;
  logic [31:0]   push_data;
  logic [4:0]    push_exc;
  logic [3:0]    push_unit;
  logic          pop;
  logic          clr_flags;
  logic [31:0]   head_data;
  logic [4:0]    head_exc;
  logic [3:0]    head_unit;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [4:0]    fflags;
  logic          overflow;
  logic          underflow;
  logic          irq;

  fpu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_exc   (push_exc),
    .push_unit  (push_unit),
    .pop        (pop),
    .clr_flags  (clr_flags),
    .head_data  (head_data),
    .head_exc   (head_exc),
    .head_unit  (head_unit),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .fflags     (fflags),
    .overflow   (overflow),
    .underflow  (underflow),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [40:0] sb[$];
  int          mcount;
  logic [4:0]  mff;
  logic        movf;
  logic        mudf;
  logic        mirq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_l) begin
      if (sb.size() == 0) begin
        chk("head_when_empty", {22'b0, empty, head_unit, head_exc, head_data}, {22'b0, 1'b1, 41'b0});
      end else begin
        chk("head_entry", {23'b0, head_unit, head_exc, head_data}, {23'b0, sb[0]});
        if (pop) sb.delete(0);
      end
    end
  end

  task automatic step(input logic pv, input logic [31:0] d, input logic [4:0] e,
                      input logic [3:0] u, input logic p, input logic clr);
    logic m_pop, m_push, m_ovf, m_udf, irq_nxt;
    logic [4:0] m_exc;
    m_pop  = p && (mcount > 0);
    m_push = pv && ((mcount < DEPTH) || m_pop);
    m_ovf  = pv && !m_push;
    m_udf  = p && (mcount == 0);
    m_exc  = m_push ? e : 5'b0;
`ifdef FPU_RESULT_QUEUE_IRQ_EN
    irq_nxt = (mcount != 0) || (mff[4:3] != 2'b00) || movf;
`else
    irq_nxt = 1'b0;
`endif
    push_valid = pv; push_data = d; push_exc = e; push_unit = u;
    pop = p; clr_flags = clr;
    @(posedge clk);
    #1;
    mcount = mcount + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    if (m_push) sb.push_back({u, e, d});
    mff  = clr ? m_exc : (mff | m_exc);
    movf = clr ? m_ovf : (movf | m_ovf);
    mudf = clr ? m_udf : (mudf | m_udf);
    mirq = irq_nxt;
    push_valid = 1'b0; push_data = '0; push_exc = '0; push_unit = '0;
    pop = 1'b0; clr_flags = 1'b0;
    chk("count", 64'(count), 64'(mcount));
    chk("empty", 64'(empty), 64'(mcount == 0));
    chk("full", 64'(full), 64'(mcount == DEPTH));
    chk("fflags", 64'(fflags), 64'(mff));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("underflow", 64'(underflow), 64'(mudf));
    chk("irq", 64'(irq), 64'(mirq));
  endtask

  task automatic model_reset();
    sb.delete();
    mcount = 0; mff = '0; movf = 1'b0; mudf = 1'b0; mirq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push_valid = 1'b0; push_data = '0; push_exc = '0; push_unit = '0;
    pop = 1'b0; clr_flags = 1'b0;
    model_reset();
    rst_l = 1'b0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty_full", {62'b0, empty, full}, 64'b10);
    chk("rst_head", {23'b0, head_unit, head_exc, head_data}, 64'd0);
    chk("rst_flags", {56'b0, fflags, overflow, underflow, irq}, 64'd0);
    @(negedge clk);
    #2;
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // Two results in order, then one pop: count 1,2,1
    step(1'b1, 32'h3F80_0000, 5'b00000, 4'd6, 1'b0, 1'b0);
    chk("s1_count1", 64'(count), 64'd1);
    step(1'b1, 32'h4000_0000, 5'b00001, 4'd7, 1'b0, 1'b0);
    chk("s1_count2", 64'(count), 64'd2);
    chk("s1_head", {28'b0, head_unit, head_data}, {28'b0, 4'd6, 32'h3F80_0000});
    step(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0);
    chk("s1_count3", 64'(count), 64'd1);
    chk("s1_head_after_pop", {32'b0, head_exc, head_data[26:0]}, {32'b0, 5'b00001, 27'h0000000});
    chk("s1_head_data", 64'(head_data), 64'h4000_0000);
    step(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b1);

    // Five pushes without popping: fifth is dropped
    step(1'b1, 32'hA000_0001, 5'b00001, 4'd1, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0002, 5'b00010, 4'd2, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0003, 5'b00100, 4'd3, 1'b0, 1'b0);
    chk("s2_not_full", 64'(full), 64'd0);
    step(1'b1, 32'hA000_0004, 5'b00001, 4'd4, 1'b0, 1'b0);
    chk("s2_full", 64'(full), 64'd1);
    step(1'b1, 32'hA000_0005, 5'b01000, 4'd5, 1'b0, 1'b0);
    chk("s2_overflow", 64'(overflow), 64'd1);
    chk("s2_fflags", 64'(fflags), 64'h07);
    chk("s2_head", 64'(head_data), 64'hA000_0001);

    // Push and pop together while full, through a full pointer wrap
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hB000_0000 + 32'(i), 5'b00000, 4'(i), 1'b1, 1'b0);
      chk("s3_count", 64'(count), 64'd4);
    end
    chk("s3_head", 64'(head_data), 64'hB000_0004);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'b0, 4'd0, 1'b0, 1'b1);
    chk("s3_cleared", {58'b0, fflags, overflow}, 64'd0);

    // Pop on empty alongside a push carrying NV
    step(1'b1, 32'hC000_0000, 5'b10000, 4'd9, 1'b1, 1'b0);
    chk("s4_underflow", 64'(underflow), 64'd1);
    chk("s4_count", 64'(count), 64'd1);
    chk("s4_fflags", 64'(fflags), 64'h10);
    step(1'b0, 32'h0, 5'b0, 4'd0, 1'b0, 1'b0);
`ifdef FPU_RESULT_QUEUE_IRQ_EN
    chk("s4_irq", 64'(irq), 64'd1);
`else
    chk("s4_irq_tied", 64'(irq), 64'd0);
`endif

    // Clear in the same cycle as a push with NX
    step(1'b1, 32'hD000_0000, 5'b00001, 4'd10, 1'b0, 1'b1);
    chk("s5_fflags", 64'(fflags), 64'h01);
    chk("s5_ovf_udf", {62'b0, overflow, underflow}, 64'd0);

    // Asynchronous reset between edges with three entries stored
    step(1'b1, 32'hE000_0000, 5'b00010, 4'd0, 1'b0, 1'b0);
    chk("s6_count3", 64'(count), 64'd3);
    @(posedge clk);
    #3;
    rst_l = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_count", 64'(count), 64'd0);
    chk("s6_rst_empty", 64'(empty), 64'd1);
    chk("s6_rst_fflags", 64'(fflags), 64'd0);
    chk("s6_rst_head", 64'(head_data), 64'd0);
    #4;
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hF000_0001, 5'b00100, 4'd3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
